// File: rtl/ccl_frame_sequencer.sv
// rtl/ccl_frame_sequencer.sv - CCL frame controller: scan, one-line flush, label readout (option CCL_SKIP_EMPTY_EN)
module ccl_frame_sequencer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int WORD_SIZE  = 8,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_SIZE-1:0]  s_data,
    output logic                  cc_clear,
    output logic                  cc_en,
    output logic [WORD_SIZE-1:0]  cc_data,
    output logic [31:0]           cc_x,
    output logic [31:0]           cc_y,
    input  logic [WORD_SIZE-1:0]  num_labels,
    output logic                  tbl_rd_en,
    output logic [WORD_SIZE-1:0]  tbl_addr,
    input  logic [DATA_WIDTH-1:0] tbl_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_SIZE-1:0]  m_label,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [31:0]          X_LAST  = 32'(WIDTH - 1);
    localparam logic [31:0]          Y_LAST  = 32'(HEIGHT - 1);
    localparam logic [31:0]          Y_FLUSH = 32'(HEIGHT);
    localparam logic [WORD_SIZE-1:0] ONE     = WORD_SIZE'(1);

    state_t                state;
    logic [31:0]           x_cnt;
    logic [31:0]           y_cnt;
    logic [31:0]           f_cnt;
    logic [WORD_SIZE-1:0]  n_lab;
    logic                  loaded;
    logic [WORD_SIZE-1:0]  rd_addr;
    logic                  pend;
    logic [WORD_SIZE-1:0]  pend_label;

    logic [WORD_SIZE-1:0]  q_label [2];
    logic [DATA_WIDTH-1:0] q_data  [2];
    logic                  q_wptr;
    logic                  q_rptr;
    logic [1:0]            q_count;
`ifndef CCL_SKIP_EMPTY_EN
    logic [1:0]            q_last;
    logic                  push_last;
`endif

    logic accept;
    logic issue_done;
    logic reads_done;
    logic space;
    logic pop;
    logic push;

    // The datapath feed follows the pixel handshake in the same cycle.
    always_comb begin
        accept     = (state == ST_SCAN) && s_valid;
        cc_en      = accept || (state == ST_FLUSH);
        cc_data    = (state == ST_SCAN) ? s_data : '0;
        cc_x       = '0;
        cc_y       = '0;
        if (state == ST_SCAN) begin
            cc_x = x_cnt;
            cc_y = y_cnt;
        end else if (state == ST_FLUSH) begin
            cc_x = f_cnt;
            cc_y = Y_FLUSH;
        end

        issue_done = (rd_addr >= n_lab);
        reads_done = loaded && issue_done && !pend;

`ifdef CCL_SKIP_EMPTY_EN
        // An entry is shown only once it is known whether a later non-empty one follows.
        m_valid = (q_count == 2'd2) || ((q_count == 2'd1) && reads_done);
        m_last  = (q_count == 2'd1) && reads_done;
        push    = pend && (tbl_data != '0);
`else
        m_valid   = (q_count != 2'd0);
        m_last    = m_valid && q_last[q_rptr];
        push      = pend;
        push_last = (pend_label == (n_lab - ONE));
`endif
        m_label = q_label[q_rptr];
        m_data  = q_data[q_rptr];
        pop     = m_valid && m_ready;

        // Buffered plus in-flight entries never exceed the two skid slots.
        space     = ({1'b0, q_count} + {2'b00, pend}) < (3'd2 + {2'b00, pop});
        tbl_rd_en = (state == ST_DRAIN) && loaded && !issue_done && space;
        tbl_addr  = rd_addr;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            f_cnt      <= '0;
            n_lab      <= '0;
            loaded     <= 1'b0;
            rd_addr    <= '0;
            pend       <= 1'b0;
            pend_label <= '0;
            q_label[0] <= '0;
            q_label[1] <= '0;
            q_data[0]  <= '0;
            q_data[1]  <= '0;
            q_wptr     <= 1'b0;
            q_rptr     <= 1'b0;
            q_count    <= 2'd0;
`ifndef CCL_SKIP_EMPTY_EN
            q_last     <= 2'b00;
`endif
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            cc_clear   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cc_clear   <= 1'b0;
            frame_done <= 1'b0;

            pend <= tbl_rd_en;
            if (tbl_rd_en) begin
                pend_label <= rd_addr;
                rd_addr    <= rd_addr + ONE;
            end

            if (push) begin
                q_label[q_wptr] <= pend_label;
                q_data[q_wptr]  <= tbl_data;
`ifndef CCL_SKIP_EMPTY_EN
                q_last[q_wptr]  <= push_last;
`endif
                q_wptr          <= ~q_wptr;
            end
            if (pop) begin
                q_rptr <= ~q_rptr;
            end
            q_count <= q_count + {1'b0, push} - {1'b0, pop};

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_CLEAR;
                        cc_clear <= 1'b1;
                        busy     <= 1'b1;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                    end
                end
                ST_CLEAR: begin
                    state   <= ST_SCAN;
                    s_ready <= 1'b1;
                end
                ST_SCAN: begin
                    if (accept) begin
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            if (y_cnt == Y_LAST) begin
                                y_cnt   <= '0;
                                f_cnt   <= '0;
                                s_ready <= 1'b0;
                                state   <= ST_FLUSH;
                            end else begin
                                y_cnt <= y_cnt + 32'd1;
                            end
                        end else begin
                            x_cnt <= x_cnt + 32'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (f_cnt == X_LAST) begin
                        state   <= ST_DRAIN;
                        loaded  <= 1'b0;
                        rd_addr <= ONE;
                    end else begin
                        f_cnt <= f_cnt + 32'd1;
                    end
                end
                ST_DRAIN: begin
                    // Label count is taken one cycle late so the last flush beat has landed.
                    if (!loaded) begin
                        n_lab  <= num_labels;
                        loaded <= 1'b1;
                    end else if ((pop && m_last) || (reads_done && (q_count == 2'd0))) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    loaded <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccl_frame_sequencer.sv
// tb/tb_ccl_frame_sequencer.sv - randomized self-checking bench for ccl_frame_sequencer on a 4x2 frame
module tb_ccl_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NP = W * H;
`ifdef CCL_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        cc_clear;
    logic        cc_en;
    logic [7:0]  cc_data;
    logic [31:0] cc_x;
    logic [31:0] cc_y;
    logic [7:0]  num_labels;
    logic        tbl_rd_en;
    logic [7:0]  tbl_addr;
    logic [23:0] tbl_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_label;
    logic [23:0] m_data;
    logic        m_last;
    logic        busy;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [23:0]  tbl_mem [256];
    logic [7:0]   pix [NP];
    int           ready_mode = 0;
    logic [71:0]  beat_q [$];
    logic [32:0]  res_q [$];
    int           done_cnt  = 0;
    int           clear_cnt = 0;
    logic         prev_stall;
    logic [32:0]  prev_res;

    ccl_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .WORD_SIZE(8), .DATA_WIDTH(24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cc_clear(cc_clear), .cc_en(cc_en), .cc_data(cc_data), .cc_x(cc_x), .cc_y(cc_y),
        .num_labels(num_labels),
        .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_label(m_label), .m_data(m_data), .m_last(m_last),
        .busy(busy), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data table: one-cycle read latency.
    initial tbl_data = '0;
    always @(posedge clk) begin
        if (tbl_rd_en) tbl_data <= tbl_mem[tbl_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result-side driver and monitor.
    initial begin
        m_ready    = 1'b0;
        prev_stall = 1'b0;
        prev_res   = '0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = !m_ready;
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
            @(negedge clk);
            if (reset_n) begin
                if (cc_en) beat_q.push_back({cc_x, cc_y, cc_data});
                if (prev_stall)
                    check("m_hold", {94'd0, m_valid, m_label, m_data, m_last}, {94'd0, 1'b1, prev_res});
                if (m_valid && m_ready) res_q.push_back({m_label, m_data, m_last});
                prev_stall = m_valid && !m_ready;
                prev_res   = {m_label, m_data, m_last};
                if (frame_done) done_cnt++;
                if (cc_clear) clear_cnt++;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic send_pixels(input int gap_max);
        for (int i = 0; i < NP; i++) begin
            int t;
            repeat ($urandom_range(gap_max, 0)) begin
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = pix[i];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!s_ready && t < 50);
            if (!s_ready) check("s_ready_wait", 0, 1);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_data  = '0;
        end
    endtask

    task automatic run_frame(input string name, input int gap_max, input int rmode,
                             input int nlab, input bit hold_start);
        logic [71:0] exp_b [$];
        logic [32:0] exp_r [$];
        logic [32:0] tmp;
        int t;
        beat_q.delete();
        res_q.delete();
        done_cnt   = 0;
        clear_cnt  = 0;
        ready_mode = rmode;
        num_labels = 8'(nlab);

        @(posedge clk);
        #1;
        start = 1'b1;
        if (!hold_start) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        send_pixels(gap_max);

        t = 0;
        while (!frame_done && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({name, " done_seen"}, 128'(frame_done), 1);
        if (hold_start) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            @(negedge clk);
        end
        check({name, " busy_drop"}, 128'(busy), 0);

        for (int i = 0; i < NP; i++) exp_b.push_back({32'(i % W), 32'(i / W), pix[i]});
        for (int k = 0; k < W; k++) exp_b.push_back({32'(k), 32'(H), 8'h00});
        for (int l = 1; l < nlab; l++)
            if (!SKIP || tbl_mem[l] != 24'd0) exp_r.push_back({8'(l), tbl_mem[l], 1'b0});
        if (exp_r.size() > 0) begin
            tmp = exp_r.pop_back();
            tmp[0] = 1'b1;
            exp_r.push_back(tmp);
        end

        check({name, " beat_count"}, 128'(beat_q.size()), 128'(exp_b.size()));
        for (int i = 0; i < beat_q.size() && i < exp_b.size(); i++)
            check($sformatf("%s beat%0d", name, i), 128'(beat_q[i]), 128'(exp_b[i]));
        check({name, " result_count"}, 128'(res_q.size()), 128'(exp_r.size()));
        for (int i = 0; i < res_q.size() && i < exp_r.size(); i++)
            check($sformatf("%s result%0d", name, i), 128'(res_q[i]), 128'(exp_r[i]));
        check({name, " frame_done_count"}, 128'(done_cnt), 1);
        check({name, " cc_clear_count"}, 128'(clear_cnt), 1);
    endtask

    initial begin
        int t;
        reset_n    = 1'b0;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        num_labels = '0;
        for (int i = 0; i < 256; i++) tbl_mem[i] = 24'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs",
              {120'd0, s_ready, busy, cc_clear, cc_en, m_valid, frame_done, tbl_rd_en, m_last},
              128'd0);
        check("rst_pos", {64'd0, cc_x, cc_y}, 128'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < NP; i++) pix[i] = 8'h00;
        run_frame("zero_frame", 0, 0, 1, 1'b0);

        for (int i = 0; i < NP; i++) pix[i] = 8'($urandom_range(0, 1));
        tbl_mem[1] = 24'd5;
        tbl_mem[2] = 24'd9;
        run_frame("n3_ready", 0, 0, 3, 1'b0);
        run_frame("n3_toggle", 0, 1, 3, 1'b0);
        run_frame("n3_gaps", 3, 0, 3, 1'b0);

        tbl_mem[1] = 24'd0;
        tbl_mem[2] = 24'd7;
        tbl_mem[3] = 24'd0;
        run_frame("n4_sparse", 1, 2, 4, 1'b0);

        for (int l = 1; l < 5; l++) tbl_mem[l] = 24'($urandom_range(1, 1000));
        run_frame("start_held", 1, 2, 5, 1'b1);

        // Abort in the middle of readout.
        beat_q.delete();
        res_q.delete();
        done_cnt   = 0;
        ready_mode = 3;
        num_labels = 8'd6;
        for (int l = 1; l < 6; l++) tbl_mem[l] = 24'($urandom_range(1, 1000));
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_pixels(0);
        t = 0;
        while (!m_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("abort drain_reached", 128'(m_valid), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("abort outputs", {124'd0, busy, m_valid, s_ready, tbl_rd_en}, 128'd0);
        repeat (5) @(negedge clk);
        check("abort busy_idle", 128'(busy), 0);
        check("abort no_frame_done", 128'(done_cnt), 0);
        check("abort no_results", 128'(res_q.size()), 0);
        run_frame("after_abort", 1, 2, 4, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int nl;
            nl = $urandom_range(0, 9);
            for (int i = 0; i < NP; i++) pix[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
            for (int l = 1; l < 10; l++)
                tbl_mem[l] = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
            run_frame($sformatf("rand%0d", r), 2, $urandom_range(0, 2), nl, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
